mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single read port of `memory` between `N_PORTS` requesters, such as the eval core and an auxiliary loader/debug reader. Each requester issues a one-cycle `REQ` pulse with an address, matching the core's `MEM_REQ` style. The arbiter latches pending requests and grants them round-robin, with exactly one memory transaction in flight at a time. It routes `MEM_READY`/`MEM_DATA` back to the granted port and aborts a transaction with an error pulse if memory does not answer within `TIMEOUT` cycles.

## Interface
- `N_PORTS`, default 2: number of requesters (2..8).
- `ADDR_W`, default 12: address width; matches the cell index field of an expression word.
- `DATA_W`, default 16: memory word width.
- `TIMEOUT`, default 16: maximum number of WAIT cycles before a transaction is aborted (≥2).

Ports:
- `CLK` in 1: single clock; all logic on its rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `REQ` in N_PORTS: per-port one-cycle request pulse.
- `ADDR_IN` in N_PORTS*ADDR_W: per-port address; slice i is sampled with `REQ[i]`.
- `DATA_READY` out N_PORTS: one-cycle pulse to the served port.
- `DATA_OUT` out DATA_W: shared read data; valid only while some `DATA_READY` bit is high.
- `ERROR` out N_PORTS: one-cycle pulse on a timeout or a dropped request.
- `BUSY` out 1: high while in WAIT.
- `MEM_REQ` out 1: one-cycle request to `memory`.
- `MEM_ADDR` out ADDR_W: drives `memory.ADDR_IN`; held stable through WAIT.
- `MEM_READY` in 1: `memory.DATA_READY`.
- `MEM_DATA` in DATA_W: `memory.DATA_OUT`.

## Operation
- **Per-port pending latch.**
  - Port i is busy when `pend[i]` is set, or when the state is WAIT and `grant == i`. Busy is evaluated at the sampling edge.
  - `REQ[i]` while port i is not busy sets `pend[i]` and captures `ADDR_IN` slice i into `pend_addr[i]`.
  - `REQ[i]` while port i is busy is dropped, and `ERROR[i]` pulses the next cycle. Drop errors are independent of FSM state.
- **FSM states** are `ARB_IDLE` and `ARB_WAIT`.
- **In ARB_IDLE, with any `pend` bit set:**
  - The winner is the first set bit scanning from `last_grant+1` upward, with wrap-around.
  - On that edge: `MEM_ADDR <= pend_addr[w]`, `MEM_REQ <= 1` for one cycle, `grant <= w`, clear `pend[w]`, reset the timer to 0, and go to ARB_WAIT.
- **In ARB_IDLE, with no `pend` bit set:** stay in IDLE. A stray `MEM_READY` is ignored.
- **In ARB_WAIT:**
  - If `MEM_READY` is high: `DATA_OUT <= MEM_DATA`, `DATA_READY[grant] <= 1`, `last_grant <= grant`, go to IDLE.
  - Otherwise, when the timer equals `TIMEOUT-1`: `ERROR[grant] <= 1`, `last_grant <= grant`, go to IDLE.
  - Otherwise the timer increments.
  - `MEM_READY` takes priority over timeout in the same cycle.
- **Requests arriving during WAIT** are latched normally into `pend`, then arbitrated on return to IDLE.
- **`DATA_OUT`** holds its last value between transactions.

## Timing
- **Reset values:**
  - All outputs are 0.
  - State is ARB_IDLE, `pend` is all 0, the timer is 0.
  - `last_grant` is `N_PORTS-1`, so port 0 wins the first tie.
- **Reset mid-WAIT** abandons the transaction with no `DATA_READY` or `ERROR`. A late `MEM_READY` after reset lands in IDLE and is ignored.
- **Request latency:** `REQ[i]` high in cycle t gives `pend[i]` in t+1 and `MEM_REQ` high in t+2 if the arbiter is idle.
- **Response latency:** `MEM_READY` high in cycle m gives `DATA_READY` and `DATA_OUT` in m+1.
- **Throughput:** at least one IDLE cycle between transactions. Back-to-back throughput is one transaction per (memory latency + 2) cycles.
- **Timeout:** `ERROR` pulses exactly `TIMEOUT+1` cycles after `MEM_REQ` when `MEM_READY` never arrives.
- **`BUSY`** is high from the `MEM_REQ` cycle through the last WAIT cycle.

## Structure
- Package `mem_arb_pkg` holds:
  - the typedef `arb_state_t` (`ARB_IDLE`, `ARB_WAIT`);
  - the constants `MEM_ADDR_W = 12` and `MEM_DATA_W = 16`, shared with `core` and `memory`.
- Sub-module `rr_select` is purely combinational. Inputs are a request vector and `last_grant`; outputs are a winner index and an any-valid flag. It is reusable by later schedulers.
- The timer width is `$clog2(TIMEOUT)`.

## Test plan
- **Single request.** Port 0 pulses `REQ` with address 0x001; memory answers after 1 cycle with 0x002A. Required: `MEM_ADDR` = 0x001, `MEM_REQ` in t+2, `DATA_READY[0]` with `DATA_OUT` = 0x002A. `DATA_READY[1]` and `ERROR` stay 0.
- **Simultaneous requests.** Both ports pulse `REQ` in the same cycle, port 0 with 0x010 and port 1 with 0x020. Required: port 0 is served first, then port 1. Rerunning from that state with both pending again serves port 1 first (round-robin).
- **Timeout.** Port 1 requests 0x0FF and memory never answers (`TIMEOUT` = 16). Required: `ERROR[1]` pulses 17 cycles after `MEM_REQ`. A subsequent port 0 request completes normally.
- **Dropped request.** Port 0 pulses `REQ` twice, 1 cycle apart. Required: the second is dropped, `ERROR[0]` pulses, and exactly one `MEM_REQ` is issued for the first address.
- **Reset mid-WAIT.** Deassert `RST_N` 1 cycle during WAIT, then deliver `MEM_READY`. Required: no `DATA_READY`, all outputs 0, and the next request issues normally.
- **Stray `MEM_READY` in IDLE.** Required: no output change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read-port arbiter.
//   arb_state_t : arbiter FSM states (idle / waiting on memory)
//   MEM_ADDR_W  : memory address width, shared with core and memory
//   MEM_DATA_W  : memory word width, shared with core and memory
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 16;

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Combinational round-robin selector.
//   req        in  N_PORTS : request vector
//   last_grant in  IDX_W   : index granted most recently
//   winner     out IDX_W   : first set req bit scanning upward from last_grant+1, wrapping
//   valid      out 1       : at least one req bit is set
module rr_select #(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  always_comb begin
    winner = last_grant;
    valid  = 1'b0;
    // k runs 1..N_PORTS so last_grant itself is considered last.
    for (int k = 1; k <= N_PORTS; k++) begin
      if (!valid && req[(int'(last_grant) + k) % N_PORTS]) begin
        winner = IDX_W'((int'(last_grant) + k) % N_PORTS);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory read port between N_PORTS requesters.
// One transaction in flight at a time; unanswered transactions are aborted.
//   CLK, RST_N          : clock, synchronous active-low reset
//   REQ, ADDR_IN        : per-port one-cycle request pulse and packed addresses
//   DATA_READY, DATA_OUT: per-port completion pulse and shared read data
//   ERROR               : per-port pulse on timeout or dropped request
//   BUSY                : a memory transaction is outstanding
//   MEM_REQ, MEM_ADDR   : request pulse and held address towards memory
//   MEM_READY, MEM_DATA : response from memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [N_PORTS-1:0]       REQ,
  input  logic [N_PORTS*ADDR_W-1:0] ADDR_IN,
  output logic [N_PORTS-1:0]       DATA_READY,
  output logic [DATA_W-1:0]        DATA_OUT,
  output logic [N_PORTS-1:0]       ERROR,
  output logic                     BUSY,
  output logic                     MEM_REQ,
  output logic [ADDR_W-1:0]        MEM_ADDR,
  input  logic                     MEM_READY,
  input  logic [DATA_W-1:0]        MEM_DATA
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);

  arb_state_t          state_q, state_d;
  logic [N_PORTS-1:0]  pend_q, pend_d;
  logic [ADDR_W-1:0]   pend_addr_q [N_PORTS];
  logic [ADDR_W-1:0]   pend_addr_d [N_PORTS];
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [N_PORTS-1:0]  data_ready_q, data_ready_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [N_PORTS-1:0]  error_q, error_d;

  logic [IDX_W-1:0]    sel_winner;
  logic                sel_valid;

  rr_select #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req        (pend_q),
    .last_grant (last_grant_q),
    .winner     (sel_winner),
    .valid      (sel_valid)
  );

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    data_ready_d = '0;
    data_out_d   = data_out_q;
    error_d      = '0;

    // Pending latch: a port may hold one request, queued or in flight.
    for (int i = 0; i < N_PORTS; i++) begin
      if (REQ[i]) begin
        if (pend_q[i] || (state_q == ARB_WAIT && grant_q == IDX_W'(i))) begin
          error_d[i] = 1'b1;
        end else begin
          pend_d[i]      = 1'b1;
          pend_addr_d[i] = ADDR_IN[i*ADDR_W +: ADDR_W];
        end
      end
    end

    case (state_q)
      ARB_IDLE: begin
        if (sel_valid) begin
          mem_addr_d         = pend_addr_q[sel_winner];
          mem_req_d          = 1'b1;
          grant_d            = sel_winner;
          pend_d[sel_winner] = 1'b0;
          timer_d            = '0;
          state_d            = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (MEM_READY) begin
          data_out_d            = MEM_DATA;
          data_ready_d[grant_q] = 1'b1;
          last_grant_d          = grant_q;
          state_d               = ARB_IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          error_d[grant_q] = 1'b1;
          last_grant_d     = grant_q;
          state_d          = ARB_IDLE;
        end else if (!mem_req_q) begin
          // The MEM_REQ cycle is not counted, so the abort lands TIMEOUT+1
          // cycles after the request pulse.
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ARB_IDLE;
      pend_q       <= '0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_PORTS - 1);
      timer_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      data_ready_q <= '0;
      data_out_q   <= '0;
      error_q      <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      data_ready_q <= data_ready_d;
      data_out_q   <= data_out_d;
      error_q      <= error_d;
    end
  end

  // Queued addresses are only read while their pend bit is set.
  always_ff @(posedge CLK) begin
    pend_addr_q <= pend_addr_d;
  end

  assign DATA_READY = data_ready_q;
  assign DATA_OUT   = data_out_q;
  assign ERROR      = error_q;
  assign BUSY       = (state_q == ARB_WAIT);
  assign MEM_REQ    = mem_req_q;
  assign MEM_ADDR   = mem_addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a
// transaction-level reference model.
module tb_mem_arbiter;

  localparam int NP = 2;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    req;
  logic [NP*AW-1:0] addr_in;
  logic [NP-1:0]    data_ready;
  logic [DW-1:0]    data_out;
  logic [NP-1:0]    error;
  logic             busy;
  logic             mem_req;
  logic [AW-1:0]    mem_addr;
  logic             mem_ready;
  logic [DW-1:0]    mem_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .N_PORTS (NP),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .REQ        (req),
    .ADDR_IN    (addr_in),
    .DATA_READY (data_ready),
    .DATA_OUT   (data_out),
    .ERROR      (error),
    .BUSY       (busy),
    .MEM_REQ    (mem_req),
    .MEM_ADDR   (mem_addr),
    .MEM_READY  (mem_ready),
    .MEM_DATA   (mem_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // A port holds at most one request. One transaction is outstanding at a
  // time; m_age counts cycles since the MEM_REQ cycle (0 = MEM_REQ cycle).
  bit            m_valid = 0;
  bit [NP-1:0]   m_pend;
  logic [AW-1:0] m_paddr [NP];
  bit            m_inflight;
  int            m_port, m_age, m_last;
  logic [NP-1:0] e_ready, e_err;
  logic          e_memreq;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_dout;

  always @(posedge clk) begin
    bit [NP-1:0] old_pend;
    int w;
    if (!rst_n) begin
      m_pend = '0; m_inflight = 0; m_port = 0; m_age = 0; m_last = NP - 1;
      e_ready = '0; e_err = '0; e_memreq = 0; e_maddr = '0; e_dout = '0;
      m_valid = 1;
    end else begin
      old_pend = m_pend;
      e_ready = '0; e_err = '0; e_memreq = 0;
      for (int i = 0; i < NP; i++) begin
        if (req[i]) begin
          if (old_pend[i] || (m_inflight && m_port == i)) e_err[i] = 1'b1;
          else begin
            m_pend[i]  = 1'b1;
            m_paddr[i] = addr_in[i*AW +: AW];
          end
        end
      end
      if (m_inflight) begin
        if (mem_ready) begin
          e_ready[m_port] = 1'b1; e_dout = mem_data; m_last = m_port; m_inflight = 0;
        end else if (m_age == TO) begin
          e_err[m_port] = 1'b1; m_last = m_port; m_inflight = 0;
        end else m_age++;
      end else if (old_pend != 0) begin
        w = -1;
        for (int k = 1; k <= NP; k++)
          if (w < 0 && old_pend[(m_last + k) % NP]) w = (m_last + k) % NP;
        m_pend[w] = 1'b0;
        m_inflight = 1; m_port = w; m_age = 0;
        e_memreq = 1'b1; e_maddr = m_paddr[w];
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_data_ready", 32'(data_ready), 32'(e_ready));
      chk("m_error", 32'(error), 32'(e_err));
      chk("m_mem_req", 32'(mem_req), 32'(e_memreq));
      chk("m_mem_addr", 32'(mem_addr), 32'(e_maddr));
      chk("m_data_out", 32'(data_out), 32'(e_dout));
      chk("m_busy", 32'(busy), 32'(m_inflight));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Waits (bounded) for MEM_REQ, answers one cycle later with d.
  task automatic serve(input logic [DW-1:0] d, output logic [AW-1:0] a, output logic [NP-1:0] dr);
    int n = 0;
    while (mem_req !== 1'b1 && n < 30) begin tick(); n++; end
    if (n >= 30) begin
      errors++;
      $display("FAIL serve_wait: no MEM_REQ within 30 cycles");
    end
    a = mem_addr;
    tick();
    mem_ready = 1'b1; mem_data = d;
    tick();
    mem_ready = 1'b0;
    dr = data_ready;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [NP-1:0] dr;
    int cnt;
    rst_n = 1'b0; req = '0; addr_in = '0; mem_ready = 1'b0; mem_data = '0;
    repeat (3) tick();
    chk("reset_outputs", {data_ready, error, 12'(data_out), busy, mem_req, 12'(mem_addr)}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Single request
    req = 2'b01; addr_in = {12'h000, 12'h001};
    tick(); req = '0;
    chk("single_memreq_t1", 32'(mem_req), 32'h0);
    tick();
    chk("single_memreq_t2", 32'(mem_req), 32'h1);
    chk("single_mem_addr", 32'(mem_addr), 32'h001);
    chk("single_busy", 32'(busy), 32'h1);
    tick(); mem_ready = 1'b1; mem_data = 16'h002A;
    tick(); mem_ready = 1'b0;
    chk("single_ready", 32'(data_ready), 32'h1);
    chk("single_data", 32'(data_out), 32'h002A);
    chk("single_error", 32'(error), 32'h0);

    // Timeout on port 1, then port 0 completes
    tick();
    req = 2'b10; addr_in = {12'h0FF, 12'h000};
    tick(); req = '0;
    tick();
    chk("to_memreq", 32'(mem_req), 32'h1);
    chk("to_mem_addr", 32'(mem_addr), 32'h0FF);
    cnt = 0;
    while (error !== 2'b10 && cnt < 40) begin tick(); cnt++; end
    chk("to_latency", 32'(cnt), 32'd17);
    req = 2'b01; addr_in = {12'h000, 12'h055};
    tick(); req = '0;
    serve(16'h1234, a, dr);
    chk("to_after_addr", 32'(a), 32'h055);
    chk("to_after_ready", 32'(dr), 32'h1);

    // Dropped request
    tick();
    req = 2'b01; addr_in = {12'h000, 12'h0A0};
    tick(); req = '0;
    tick();
    chk("drop_memreq", 32'(mem_req), 32'h1);
    chk("drop_mem_addr", 32'(mem_addr), 32'h0A0);
    req = 2'b01; addr_in = {12'h000, 12'h0B0};
    tick(); req = '0;
    chk("drop_error", 32'(error), 32'h1);
    mem_ready = 1'b1; mem_data = 16'h0CAB;
    tick(); mem_ready = 1'b0;
    chk("drop_ready", 32'(data_ready), 32'h1);
    chk("drop_data", 32'(data_out), 32'h0CAB);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (mem_req === 1'b1) cnt++; end
    chk("drop_no_extra_memreq", 32'(cnt), 32'd0);

    // Reset mid-WAIT, late MEM_READY ignored, next request normal
    req = 2'b01; addr_in = {12'h000, 12'h077};
    tick(); req = '0;
    tick(); tick();
    chk("rst_in_wait", 32'(busy), 32'h1);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    chk("rst_outputs", {data_ready, error, 12'(data_out), busy, mem_req, 12'(mem_addr)}, 32'h0);
    mem_ready = 1'b1; mem_data = 16'hBEEF;
    tick(); mem_ready = 1'b0;
    chk("rst_late_ready", 32'(data_ready), 32'h0);
    chk("rst_late_data", 32'(data_out), 32'h0);
    req = 2'b10; addr_in = {12'h033, 12'h000};
    tick(); req = '0;
    serve(16'h3333, a, dr);
    chk("rst_next_addr", 32'(a), 32'h033);
    chk("rst_next_ready", 32'(dr), 32'h2);

    // Simultaneous requests: last grant was port 1, so port 0 first
    tick();
    req = 2'b11; addr_in = {12'h020, 12'h010};
    tick(); req = '0;
    serve(16'h1111, a, dr);
    chk("sim1_first_addr", 32'(a), 32'h010);
    chk("sim1_first_ready", 32'(dr), 32'h1);
    serve(16'h2222, a, dr);
    chk("sim1_second_addr", 32'(a), 32'h020);
    chk("sim1_second_ready", 32'(dr), 32'h2);
    // Serve port 0 alone, then both pending again: port 1 first
    tick();
    req = 2'b01; addr_in = {12'h000, 12'h011};
    tick(); req = '0;
    serve(16'h4444, a, dr);
    tick();
    req = 2'b11; addr_in = {12'h021, 12'h012};
    tick(); req = '0;
    serve(16'h5555, a, dr);
    chk("sim2_first_addr", 32'(a), 32'h021);
    chk("sim2_first_ready", 32'(dr), 32'h2);
    serve(16'h6666, a, dr);
    chk("sim2_second_addr", 32'(a), 32'h012);
    chk("sim2_second_ready", 32'(dr), 32'h1);

    // Stray MEM_READY in IDLE
    tick(); tick();
    mem_ready = 1'b1; mem_data = 16'hDEAD;
    tick(); mem_ready = 1'b0;
    chk("stray_ready", 32'(data_ready), 32'h0);
    chk("stray_data", 32'(data_out), 32'h6666);
    chk("stray_error", 32'(error), 32'h0);
    chk("stray_memreq", 32'(mem_req), 32'h0);

    // Randomized traffic; second half answers rarely to provoke timeouts
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NP; i++) req[i] = ($urandom_range(0, 3) == 0);
      addr_in   = (NP*AW)'({$urandom, $urandom});
      mem_data  = 16'($urandom);
      mem_ready = (c < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    req = '0; mem_ready = 1'b0; rst_n = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
